// File: rtl/acc_cpu_ctrl_pkg.sv
// Shared types and codes for the accumulator CPU controller.
// Opcodes, ALU/B-source selects, state encoding and control word.
package acc_cpu_ctrl_pkg;

  localparam int OPW    = 3;
  localparam int ALUOPW = 2;

  typedef enum logic [2:0] {
    OP_LDA = 3'b000,
    OP_STA = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_JMP = 3'b100,
    OP_JZ  = 3'b101,
    OP_AND = 3'b110,
    OP_NOT = 3'b111
  } opcode_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] B_ZERO = 2'b00;
  localparam logic [1:0] B_ONE  = 2'b01;
  localparam logic [1:0] B_MDR  = 2'b10;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMRD  = 4'd3,
    S_LDWB   = 4'd4,
    S_ALUWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_JUMP   = 4'd7,
    S_JZT    = 4'd8,
    S_ALUNOT = 4'd9
  } state_t;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       ldir;
    logic       ldmdr;
    logic       ldacc;
    logic       iord;
    logic       asrc;
    logic [1:0] bsrc;
    logic       pcsrc;
    logic       pcwrite;
    logic       jz;
    logic       accsrc;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic [1:0] alu_of(opcode_t op);
    unique case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/acc_cpu_ctrl_dec.sv
// Control-word decoder: (state, latched opcode) -> datapath strobes.
// Purely combinational; illegal states decode to all-zero.
module acc_cpu_ctrl_dec
  import acc_cpu_ctrl_pkg::*;
(
  input  state_t  st,
  input  opcode_t op,
  output ctrl_t   cw
);

  // Moore output table; unlisted fields stay 0
  always_comb begin
    cw = '0;
    unique case (st)
      S_FETCH: begin
        cw.memread = 1'b1;
        cw.ldir    = 1'b1;
        cw.bsrc    = B_ONE;
        cw.aluop   = ALU_ADD;
        cw.pcwrite = 1'b1;
      end
      S_MEMRD: begin
        cw.memread = 1'b1;
        cw.iord    = 1'b1;
        cw.ldmdr   = 1'b1;
      end
      S_LDWB: begin
        cw.accsrc = 1'b1;
        cw.ldacc  = 1'b1;
      end
      S_ALUWB: begin
        cw.asrc  = 1'b1;
        cw.bsrc  = B_MDR;
        cw.aluop = alu_of(op);
        cw.ldacc = 1'b1;
      end
      S_MEMWR: begin
        cw.memwrite = 1'b1;
        cw.iord     = 1'b1;
      end
      S_JUMP: begin
        cw.pcsrc   = 1'b1;
        cw.pcwrite = 1'b1;
      end
      S_JZT: begin
        cw.asrc  = 1'b1;
        cw.bsrc  = B_ZERO;
        cw.aluop = ALU_ADD;
        cw.pcsrc = 1'b1;
        cw.jz    = 1'b1;
      end
      S_ALUNOT: begin
        cw.asrc  = 1'b1;
        cw.aluop = ALU_NOT;
        cw.ldacc = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/acc_cpu_ctrl.sv
// Multicycle Moore controller for the 16-bit accumulator CPU.
// Holds state register, opcode latch and next-state logic.
module acc_cpu_ctrl
  import acc_cpu_ctrl_pkg::*;
#(
  parameter int OPW    = 3,
  parameter int ALUOPW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPW-1:0]    opcode,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              ldIR,
  output logic              ldMDR,
  output logic              ldAcc,
  output logic              IorD,
  output logic              Asrc,
  output logic [1:0]        Bsrc,
  output logic              PCsrc,
  output logic              PCwrite,
  output logic              jz,
  output logic              AccSrc,
  output logic [ALUOPW-1:0] ALUop
);

  state_t  st, nxt;
  opcode_t op_q;
  opcode_t op_in;
  ctrl_t   cw;

  assign op_in = opcode_t'(opcode);

  // State register; reset forces INIT at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_INIT;
    else        st <= nxt;
  end

  // Opcode is captured only while decoding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              op_q <= OP_LDA;
    else if (st == S_DECODE) op_q <= op_in;
  end

  // Sequencing; unknown codes fall back to INIT
  always_comb begin
    nxt = S_INIT;
    unique case (st)
      S_INIT:   nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        unique case (op_in)
          OP_STA:  nxt = S_MEMWR;
          OP_JMP:  nxt = S_JUMP;
          OP_JZ:   nxt = S_JZT;
          OP_NOT:  nxt = S_ALUNOT;
          default: nxt = S_MEMRD;
        endcase
      end
      S_MEMRD:  nxt = (op_q == OP_LDA) ? S_LDWB : S_ALUWB;
      S_LDWB:   nxt = S_FETCH;
      S_ALUWB:  nxt = S_FETCH;
      S_MEMWR:  nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_JZT:    nxt = S_FETCH;
      S_ALUNOT: nxt = S_FETCH;
      default:  nxt = S_INIT;
    endcase
  end

  acc_cpu_ctrl_dec u_dec (
    .st (st),
    .op (op_q),
    .cw (cw)
  );

  assign MemRead  = cw.memread;
  assign MemWrite = cw.memwrite;
  assign ldIR     = cw.ldir;
  assign ldMDR    = cw.ldmdr;
  assign ldAcc    = cw.ldacc;
  assign IorD     = cw.iord;
  assign Asrc     = cw.asrc;
  assign Bsrc     = cw.bsrc;
  assign PCsrc    = cw.pcsrc;
  assign PCwrite  = cw.pcwrite;
  assign jz       = cw.jz;
  assign AccSrc   = cw.accsrc;
  assign ALUop    = cw.aluop[ALUOPW-1:0];

endmodule

// File: tb/tb_acc_cpu_ctrl.sv
// Bench for acc_cpu_ctrl: per-instruction expected strobe
// sequences, directed cases plus random instruction streams.
module tb_acc_cpu_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] opcode;
  logic       MemRead, MemWrite, ldIR, ldMDR, ldAcc, IorD, Asrc;
  logic [1:0] Bsrc;
  logic       PCsrc, PCwrite, jz, AccSrc;
  logic [1:0] ALUop;

  int checks = 0;
  int errors = 0;

  acc_cpu_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .ldIR     (ldIR),
    .ldMDR    (ldMDR),
    .ldAcc    (ldAcc),
    .IorD     (IorD),
    .Asrc     (Asrc),
    .Bsrc     (Bsrc),
    .PCsrc    (PCsrc),
    .PCwrite  (PCwrite),
    .jz       (jz),
    .AccSrc   (AccSrc),
    .ALUop    (ALUop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {MemRead,MemWrite,ldIR,ldMDR,ldAcc,IorD,Asrc,Bsrc,PCsrc,PCwrite,jz,AccSrc,ALUop}
  function automatic logic [14:0] w(
    bit mr, bit mw, bit ir, bit mdr, bit acc, bit iord, bit as,
    logic [1:0] bs, bit pcs, bit pcw, bit z, bit accs, logic [1:0] alu);
    return {mr, mw, ir, mdr, acc, iord, as, bs, pcs, pcw, z, accs, alu};
  endfunction

  function automatic logic [14:0] obs();
    return {MemRead, MemWrite, ldIR, ldMDR, ldAcc, IorD, Asrc,
            Bsrc, PCsrc, PCwrite, jz, AccSrc, ALUop};
  endfunction

  function automatic int ilen(logic [2:0] op);
    if (op == 3'b000 || op == 3'b010 || op == 3'b011 || op == 3'b110)
      return 4;
    return 3;
  endfunction

  // Expected strobes for cycle k of instruction op (k=0 is FETCH)
  function automatic logic [14:0] model(logic [2:0] op, int k);
    logic [1:0] alu;
    if (k == 0) return w(1,0,1,0,0,0,0,2'b01,0,1,0,0,2'b00);
    if (k == 1) return '0;
    case (op)
      3'b001: return w(0,1,0,0,0,1,0,2'b00,0,0,0,0,2'b00);
      3'b100: return w(0,0,0,0,0,0,0,2'b00,1,1,0,0,2'b00);
      3'b101: return w(0,0,0,0,0,0,1,2'b00,1,0,1,0,2'b00);
      3'b111: return w(0,0,0,0,1,0,1,2'b00,0,0,0,0,2'b11);
      default: begin
        if (k == 2) return w(1,0,0,1,0,1,0,2'b00,0,0,0,0,2'b00);
        if (op == 3'b000) return w(0,0,0,0,1,0,0,2'b00,0,0,0,1,2'b00);
        alu = (op == 3'b011) ? 2'b01 : (op == 3'b110) ? 2'b10 : 2'b00;
        return w(0,0,0,0,1,0,1,2'b10,0,0,0,0,alu);
      end
    endcase
  endfunction

  task automatic check(input logic [14:0] e, input string tag);
    logic [14:0] o;
    o = obs();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Check current cycle, drive opcode, advance one clock
  task automatic cyc(input logic [14:0] e, input logic [2:0] drv,
                     input string tag);
    check(e, tag);
    opcode = drv;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [2:0] op, input bit rnd);
    logic [2:0] drv;
    for (int k = 0; k < ilen(op); k++) begin
      drv = rnd ? 3'($urandom_range(7)) : 3'b000;
      if (k == 1) drv = op;
      cyc(model(op, k), drv, $sformatf("op%0d_k%0d", op, k));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 3'b000;
    repeat (3) begin
      @(posedge clk);
      #1;
      check('0, "reset_hold");
    end
    rst_n = 1'b1;
    cyc('0, 3'b111, "init_after_reset");

    run_instr(3'b000, 1'b1);
    run_instr(3'b011, 1'b0);
    run_instr(3'b001, 1'b1);
    run_instr(3'b101, 1'b1);
    run_instr(3'b111, 1'b1);
    run_instr(3'b111, 1'b1);
    run_instr(3'b100, 1'b1);
    run_instr(3'b010, 1'b1);
    run_instr(3'b110, 1'b1);

    for (int i = 0; i < 60; i++)
      run_instr(3'($urandom_range(7)), 1'b1);

    cyc(model(3'b001, 0), 3'b010, "sta_fetch");
    cyc(model(3'b001, 1), 3'b001, "sta_decode");
    check(model(3'b001, 2), "sta_memwr");
    #3;
    rst_n = 1'b0;
    #1;
    check('0, "async_reset_memwr");
    @(posedge clk);
    #1;
    check('0, "reset_held_mid");
    rst_n = 1'b1;
    cyc('0, 3'b000, "init_after_abort");
    run_instr(3'b000, 1'b1);
    run_instr(3'b101, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
